// File: rtl/reflet_float_mult_arbiter.sv
// Two-requester arbiter in front of one shared pipelined float multiplier.
// Define REFLET_FLOAT_MULT_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module reflet_float_mult_arbiter #(
  parameter int unsigned float_size   = 32,
  parameter int unsigned mult_latency = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [float_size-1:0] req0_in1,
  input  logic [float_size-1:0] req0_in2,
  output logic                  res0_valid,
  output logic [float_size-1:0] res0_data,
  input  logic                  res0_ack,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [float_size-1:0] req1_in1,
  input  logic [float_size-1:0] req1_in2,
  output logic                  res1_valid,
  output logic [float_size-1:0] res1_data,
  input  logic                  res1_ack,
  output logic                  mult_enable,
  output logic [float_size-1:0] mult_in1,
  output logic [float_size-1:0] mult_in2,
  input  logic [float_size-1:0] mult_result
);

  localparam logic [3:0] LAT_INIT = 4'(mult_latency);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t     state;
  logic       owner;
  logic [3:0] cnt;
  logic       grant1;
  logic       owner_ack;

`ifdef REFLET_FLOAT_MULT_ARB_FIXED_PRIO_EN
  assign grant1 = req1_valid & ~req0_valid;
`else
  logic rr_ptr;

  assign grant1 = req1_valid & (~req0_valid | rr_ptr);

  // Pointer moves to the requester not just served, only when an op completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= 1'b0;
    end else if (state == DONE && owner_ack) begin
      rr_ptr <= ~owner;
    end
  end
`endif

  // Ready is gated by reset so every output reads 0 while reset is held.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (reset && state == IDLE) begin
      req0_ready = req0_valid & ~grant1;
      req1_ready = grant1;
    end
  end

  assign owner_ack = owner ? res1_ack : res0_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      cnt         <= '0;
      mult_enable <= 1'b0;
      mult_in1    <= '0;
      mult_in2    <= '0;
      res0_valid  <= 1'b0;
      res0_data   <= '0;
      res1_valid  <= 1'b0;
      res1_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            mult_in1    <= grant1 ? req1_in1 : req0_in1;
            mult_in2    <= grant1 ? req1_in2 : req0_in2;
            mult_enable <= 1'b1;
            cnt         <= LAT_INIT;
            owner       <= grant1;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (owner) begin
              res1_data  <= mult_result;
              res1_valid <= 1'b1;
            end else begin
              res0_data  <= mult_result;
              res0_valid <= 1'b1;
            end
            state <= DONE;
          end
        end
        DONE: begin
          if (owner_ack) begin
            if (owner) res1_valid <= 1'b0;
            else       res0_valid <= 1'b0;
            mult_enable <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
